// File: rtl/blackjack_pkg.sv
// Shared constants, deck limits and FSM state type for the card dealing logic.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package blackjack_pkg;

  // Legal card values produced by the free-running counter.
  localparam int CARD_MIN = 1;
  localparam int CARD_MAX = 10;

  // One deck holds four of each value 1..9 and sixteen ten-valued cards (10,J,Q,K).
  localparam int DECK_LIMIT_LOW = 4;
  localparam int DECK_LIMIT_TEN = 16;
  localparam int DECK_CNT_W     = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    DONE   = 2'd2
  } deal_state_t;

  function automatic logic [DECK_CNT_W-1:0] deck_limit(input int value);
    return (value == CARD_MAX) ? DECK_CNT_W'(DECK_LIMIT_TEN) : DECK_CNT_W'(DECK_LIMIT_LOW);
  endfunction

endpackage

// File: rtl/key_sync_edge.sv
// Synchronises one raw active-low push button and flags each new press.
// Latency: press is high for one cycle, SYNC_STAGES edges after the key is first sampled low.
// Backpressure: none; a held key produces a single pulse.
// Ports: clock, reset_n (async, active-low), key_n (raw key), press (1-cycle pulse).
module key_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic key_n,
  output logic press
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], key_n};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Both terms come from flops, so the 1->0 detect is glitch-free.
  assign press = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/card_deal_arbiter.sv
// Shares one free-running 1..10 card counter between player and dealer keys, round-robin.
// Latency: uncontended press to x_valid is SYNC_STAGES+3 edges; SAMPLE retries until card_in is usable.
// Backpressure: one pending request per requester; extra presses and presses on a full hand are dropped.
// Ports: Clock, reset_n, card_in, key_p_n/key_d_n (raw keys), new_round (clear pulse);
//        p_card/d_card, p_valid/d_valid, p_count/d_count, grant {dealer,player}, busy.
// Optional: define CARD_DEAL_NODUP_EN to stop dealing values already exhausted from the deck.
module card_deal_arbiter
  import blackjack_pkg::*;
#(
  parameter int CARD_W      = 5,
  parameter int MAX_CARDS   = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic              Clock,
  input  logic              reset_n,
  input  logic [CARD_W-1:0] card_in,
  input  logic              key_p_n,
  input  logic              key_d_n,
  input  logic              new_round,
  output logic [CARD_W-1:0] p_card,
  output logic [CARD_W-1:0] d_card,
  output logic              p_valid,
  output logic              d_valid,
  output logic [2:0]        p_count,
  output logic [2:0]        d_count,
  output logic [1:0]        grant,
  output logic              busy
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_CARDS);

  logic        p_press, d_press;
  logic        p_pending, d_pending;
  logic        serve_d;
  logic        pick_d;
  logic        card_avail;
  logic        take;
  deal_state_t state;

  key_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_p (
    .clock   (Clock),
    .reset_n (reset_n),
    .key_n   (key_p_n),
    .press   (p_press)
  );

  key_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_d (
    .clock   (Clock),
    .reset_n (reset_n),
    .key_n   (key_d_n),
    .press   (d_press)
  );

`ifdef CARD_DEAL_NODUP_EN
  logic [DECK_CNT_W-1:0] deck_cnt [CARD_MIN:CARD_MAX];

  // A value is usable only while the deck still holds a copy of it.
  always_comb begin
    card_avail = 1'b0;
    for (int v = CARD_MIN; v <= CARD_MAX; v++) begin
      if (card_in == CARD_W'(v)) card_avail = (deck_cnt[v] < deck_limit(v));
    end
  end

  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int v = CARD_MIN; v <= CARD_MAX; v++) deck_cnt[v] <= '0;
    end else if (new_round) begin
      for (int v = CARD_MIN; v <= CARD_MAX; v++) deck_cnt[v] <= '0;
    end else if (take) begin
      for (int v = CARD_MIN; v <= CARD_MAX; v++) begin
        if (card_in == CARD_W'(v)) deck_cnt[v] <= deck_cnt[v] + 1'b1;
      end
    end
  end
`else
  always_comb begin
    card_avail = (card_in >= CARD_W'(CARD_MIN)) && (card_in <= CARD_W'(CARD_MAX));
  end
`endif

  always_comb begin
    take   = (state == SAMPLE) && card_avail;
    // Dealer wins only if alone, or if the player had the last grant.
    pick_d = d_pending && (!p_pending || (grant == 2'b01));
  end

  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      p_pending <= 1'b0;
      d_pending <= 1'b0;
      serve_d   <= 1'b0;
      p_card    <= '0;
      d_card    <= '0;
      p_count   <= '0;
      d_count   <= '0;
      p_valid   <= 1'b0;
      d_valid   <= 1'b0;
      grant     <= 2'b00;
      busy      <= 1'b0;
    end else if (new_round) begin
      // Also swallows any press detected this cycle and aborts a grant in flight.
      state     <= IDLE;
      p_pending <= 1'b0;
      d_pending <= 1'b0;
      serve_d   <= 1'b0;
      p_card    <= '0;
      d_card    <= '0;
      p_count   <= '0;
      d_count   <= '0;
      p_valid   <= 1'b0;
      d_valid   <= 1'b0;
      grant     <= 2'b00;
      busy      <= 1'b0;
    end else begin
      p_valid <= 1'b0;
      d_valid <= 1'b0;

      // Set only when idle for that requester and the hand has room; the
      // serving branch below clears only an already-set pending, so no overlap.
      if (p_press && !p_pending && (p_count != MAX_CNT)) p_pending <= 1'b1;
      if (d_press && !d_pending && (d_count != MAX_CNT)) d_pending <= 1'b1;

      case (state)
        IDLE: begin
          if (p_pending || d_pending) begin
            serve_d <= pick_d;
            state   <= SAMPLE;
            busy    <= 1'b1;
          end
        end
        SAMPLE: begin
          if (take) begin
            if (serve_d) begin
              d_card    <= card_in;
              d_pending <= 1'b0;
              d_valid   <= 1'b1;
              grant     <= 2'b10;
              if (d_count != MAX_CNT) d_count <= d_count + 3'd1;
            end else begin
              p_card    <= card_in;
              p_pending <= 1'b0;
              p_valid   <= 1'b1;
              grant     <= 2'b01;
              if (p_count != MAX_CNT) p_count <= p_count + 3'd1;
            end
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
